e_mdu: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the E stage; it sits beside the E-stage ALU and adds the HI/LO register pair. It accepts signed and unsigned multiply and divide, holds the result for a fixed, parameter-set number of cycles, and exposes `Busy` so the hazard unit can stall later MD instructions. MFHI/MFLO reads are combinational from HI/LO; MTHI/MTLO writes take effect on the next clock edge.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/e_mdu_calc.sv | 76 +++++++
 rtl/e_mdu.sv | 85 ++++++++
 tb/tb_e_mdu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MD-operation encodings for the E-stage multiply/divide unit,
// the instruction decoder and the hazard unit.
// No ports; provides MD_* opcode constants and small opcode classifiers.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  function automatic logic md_is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational HI/LO result for MULT, MULTU, DIV and DIVU, including the
// divide-by-zero and signed-overflow cases.
// Ports: op (MDOp), a/b (operands) -> hi/lo (result pair; 0 for other ops).
module e_mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   div_a;
  logic [WIDTH-1:0]   div_b;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;
  logic               is_signed_div;

  // Sign-extend to full product width so the multiply is done at 2*WIDTH.
  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed division is done on magnitudes with one unsigned divider; the
  // signs are reapplied afterwards (quotient truncates toward zero,
  // remainder follows the dividend).
  assign is_signed_div = (op == MD_DIV);
  assign a_neg = is_signed_div && a[WIDTH-1];
  assign b_neg = is_signed_div && b[WIDTH-1];
  assign mag_a = a_neg ? (~a + 1'b1) : a;
  assign mag_b = b_neg ? (~b + 1'b1) : b;
  assign div_a = mag_a;
  // Keep the divider away from a zero divisor; that case is overridden below.
  assign div_b = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
  assign uq    = div_a / div_b;
  assign ur    = div_a % div_b;

  always_comb begin
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT: begin
        hi = prod_s[2*WIDTH-1:WIDTH];
        lo = prod_s[WIDTH-1:0];
      end
      MD_MULTU: begin
        hi = prod_u[2*WIDTH-1:WIDTH];
        lo = prod_u[WIDTH-1:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b == '0) begin
          lo = '1;
          hi = a;
        end else if (is_signed_div && (a == MOST_NEG) && (b == '1)) begin
          lo = a;
          hi = '0;
        end else begin
          lo = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
          hi = a_neg ? (~ur + 1'b1) : ur;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers and a fixed-latency
// busy window per operation; MFHI/MFLO read combinationally via MDOut.
// Ports: clk, reset (async active-low), Start/MDOp/A/B in; Busy, HI, LO, MDOut out.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDOut
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;

  e_mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op (MDOp),
    .a  (A),
    .b  (B),
    .hi (calc_hi),
    .lo (calc_lo)
  );

  assign Busy = (cnt != '0);

  // Priority chain: any nonzero count means busy, so a Start only reaches
  // the opcode decode when the unit is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      HI      <= '0;
      LO      <= '0;
    end else if (cnt == CW'(1)) begin
      HI  <= pend_hi;
      LO  <= pend_lo;
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else if (Start) begin
      if (md_is_mul(MDOp)) begin
        pend_hi <= calc_hi;
        pend_lo <= calc_lo;
        cnt     <= CW'(MULT_CYCLES);
      end else if (md_is_div(MDOp)) begin
        pend_hi <= calc_hi;
        pend_lo <= calc_lo;
        cnt     <= CW'(DIV_CYCLES);
      end else if (MDOp == MD_MTHI) begin
        HI <= A;
      end else if (MDOp == MD_MTLO) begin
        LO <= A;
      end
    end
  end

  // Read port ignores Start and Busy: during an operation it returns the
  // committed HI/LO, not the pending result.
  always_comb begin
    MDOut = '0;
    case (MDOp)
      MD_MFHI: MDOut = HI;
      MD_MFLO: MDOut = LO;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   mdop = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] mdout;

  e_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (start),
    .MDOp  (mdop),
    .A     (a),
    .B     (b),
    .Busy  (busy),
    .HI    (hi),
    .LO    (lo),
    .MDOut (mdout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: committed HI/LO, the result waiting to commit, and the
  // absolute edge number at which it commits.
  logic [W-1:0] m_hi, m_lo, m_phi, m_plo;
  int           m_cyc  = 0;
  int           m_done = 0;

  function automatic void ref_calc(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    rh = '0;
    rl = '0;
    case (op)
      4'd1: begin sp = sx * sy; rh = sp[63:32]; rl = sp[31:0]; end
      4'd2: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
      4'd3: begin
        if (y == 0) begin rl = '1; rh = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rl = x; rh = '0; end
        else begin sq = sx / sy; sr = sx % sy; rl = sq[31:0]; rh = sr[31:0]; end
      end
      4'd4: begin
        if (y == 0) begin rl = '1; rh = x; end
        else begin up = ux / uy; rl = up[31:0]; up = ux % uy; rh = up[31:0]; end
      end
      default: ;
    endcase
  endfunction

  function automatic void model_clear();
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_done = 0;
  endfunction

  function automatic void model_edge(input logic st, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic was_busy;
    m_cyc++;
    was_busy = (m_cyc <= m_done);
    if (m_cyc == m_done) begin m_hi = m_phi; m_lo = m_plo; end
    if (st && !was_busy) begin
      case (op)
        4'd1, 4'd2: begin ref_calc(op, x, y, m_phi, m_plo); m_done = m_cyc + MC; end
        4'd3, 4'd4: begin ref_calc(op, x, y, m_phi, m_plo); m_done = m_cyc + DC; end
        4'd7: m_hi = x;
        4'd8: m_lo = x;
        default: ;
      endcase
    end
  endfunction

  // One clock: drive at the falling edge, check all outputs, then model the rising edge.
  task automatic cycle(input logic st, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic bsy);
    logic [W-1:0] exp_md;
    @(negedge clk);
    start = st; mdop = op; a = x; b = y;
    #1;
    exp_md = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : '0;
    check("busy",  {31'b0, busy}, {31'b0, (m_cyc < m_done)});
    check("hi",    hi, m_hi);
    check("lo",    lo, m_lo);
    check("mdout", mdout, exp_md);
    bsy = busy;
    @(posedge clk);
    model_edge(st, op, x, y);
  endtask

  // Issue one op, then idle; returns how many idle cycles showed Busy.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int n_idle, output int busy_cnt);
    logic bsy;
    busy_cnt = 0;
    cycle(1'b1, op, x, y, bsy);
    for (int i = 0; i < n_idle; i++) begin
      cycle(1'b0, 4'd0, '0, '0, bsy);
      if (bsy) busy_cnt++;
    end
    #1;
  endtask

  // Called just after a rising edge: asserts reset mid-cycle, releases before the next edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    model_clear();
    #1;
    check("rst_busy", {31'b0, busy}, '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    #1 reset = 1'b1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bc;
    logic bsy;
    logic [W-1:0] hi_save;

    model_clear();
    #1 reset = 1'b0;
    mdop = 4'd5;
    #1;
    check("init_busy", {31'b0, busy}, '0);
    check("init_hi", hi, '0);
    check("init_lo", lo, '0);
    check("init_mdout", mdout, '0);
    #1 reset = 1'b1;

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, MC + 1, bc);
    check("mult_busy_len", bc, MC);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, MC + 1, bc);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, DC + 1, bc);
    check("div_busy_len", bc, DC);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    run_op(4'd4, 32'd7, 32'd2, DC + 1, bc);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    run_op(4'd4, 32'd5, 32'd0, DC + 1, bc);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd5);

    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC + 1, bc);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // Starts during Busy must be ignored and must not stretch the window.
    bc = 0;
    cycle(1'b1, 4'd1, 32'd3, 32'd5, bsy);
    cycle(1'b1, 4'd1, 32'd2, 32'd2, bsy);      if (bsy) bc++;
    cycle(1'b1, 4'd7, 32'h1234, 32'd0, bsy);   if (bsy) bc++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'd0, '0, '0, bsy);
      if (bsy) bc++;
    end
    #1;
    check("ign_busy_len", bc, MC);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd15);

    hi_save = hi;
    cycle(1'b1, 4'd8, 32'hCAFE, 32'd0, bsy);
    cycle(1'b1, 4'd6, 32'd0, 32'd0, bsy);
    #1;
    check("mflo_val", mdout, 32'hCAFE);
    check("mtlo_hi_kept", hi, hi_save);
    cycle(1'b1, 4'd7, 32'hBEEF, 32'd0, bsy);
    cycle(1'b0, 4'd5, 32'd0, 32'd0, bsy);
    #1;
    check("mfhi_val", mdout, 32'hBEEF);
    check("mthi_lo_kept", lo, 32'hCAFE);

    // Reset in the middle of a divide: nothing may be written back later.
    cycle(1'b1, 4'd3, 32'd100, 32'd7, bsy);
    cycle(1'b0, 4'd0, '0, '0, bsy);
    cycle(1'b0, 4'd0, '0, '0, bsy);
    do_reset();
    for (int i = 0; i < DC + 2; i++) cycle(1'b0, 4'd0, '0, '0, bsy);
    #1;
    check("rst_nowb_hi", hi, '0);
    check("rst_nowb_lo", lo, '0);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 10));
      cycle(($urandom_range(0, 2) != 0), op, pick_operand(), pick_operand(), bsy);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
